// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit queue
//   Provides the transmit FSM state encoding, the byte width, the serializer
//   start timeout and the lost-start retry bound.
package uart_pkg;

  localparam int BYTE_W       = 8;
  // Cycles spent waiting for the serializer to drop tx_status before re-pulsing.
  localparam int BUSY_TIMEOUT = 4;
  // Re-pulses allowed after the first tx_en before the byte is abandoned.
  localparam int MAX_RETRY    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/count
//   CLK, Reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data; taken when not full or popping
//   pop, dout    : read request and head-of-queue data (dout is combinational)
//   full, empty  : registered occupancy flags
//   count        : registered occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // A push into a full FIFO is still taken when the head leaves the same edge.
  assign push_ok = push && (!full_q || pop);
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - buffered transmit front-end feeding a UART serializer
//   CLK, Reset_n        : clock, asynchronous active-low reset
//   wr_en, wr_data      : byte push from the bus write path
//   clr_ovf             : clears the sticky overflow flag
//   tx_status           : serializer status, 1 = idle, 0 = busy
//   tx_en, tx_data      : one-cycle start pulse and the byte held for the frame
//   full, empty, count  : FIFO occupancy
//   overflow            : sticky, set on a dropped push or an abandoned byte
//   busy                : FSM active or bytes still queued
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_status,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  localparam logic [2:0] WAIT_LAST = 3'(BUSY_TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  tx_state_e         state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [2:0]        retry_q, retry_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              overflow_q, overflow_d;

  logic              pop;
  logic              retry_drop;
  logic              push_drop;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .push    (wr_en),
    .pop     (pop),
    .din     (wr_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      retry_q    <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retry_q    <= retry_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retry_d    = retry_q;
    pop        = 1'b0;
    retry_drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && tx_status) begin
          pop     = 1'b1;
          retry_d = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_status) begin
          state_d = ST_WAIT_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Serializer never acknowledged the start: re-pulse, or give up on
          // this byte once the retry budget is spent.
          if (retry_q == RETRY_MAX) begin
            retry_drop = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = ST_LAUNCH;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_status) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Push is lost only when full and the head is not leaving this same edge.
  assign push_drop = wr_en && fifo_full && !pop;

  always_comb begin
    // tx_en follows LAUNCH by one register stage, so it lands in the first
    // WAIT_BUSY cycle and can never be high on two consecutive cycles.
    tx_en_d   = (state_q == ST_LAUNCH);
    tx_data_d = pop ? fifo_dout : tx_data_q;
    if (push_drop || retry_drop) overflow_d = 1'b1;
    else if (clr_ovf)            overflow_d = 1'b0;
    else                         overflow_d = overflow_q;
    busy = (state_q != ST_IDLE) || !fifo_empty;
  end

  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       tx_status;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;

  uart_tx_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .tx_status (tx_status),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Serializer model: accepts a start pulse unless told to ignore it, then
  // stays busy for frame_len cycles. ser_hold forces it busy.
  int   ser_cnt     = 0;
  int   frame_len   = 10;
  int   ignore_left = 0;
  logic ser_hold    = 1'b0;

  assign tx_status = !(ser_hold || ser_cnt != 0);

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ser_cnt <= 0;
    end else if (tx_en && ignore_left > 0) begin
      ignore_left <= ignore_left - 1;
    end else if (tx_en) begin
      ser_cnt <= frame_len;
    end else if (ser_cnt != 0) begin
      ser_cnt <= ser_cnt - 1;
    end
  end

  // Scoreboard: bytes expected on the serializer, in order.
  logic [7:0] exp_q[$];
  int         txen_cycs[$];
  int         n_txen    = 0;
  int         n_frames  = 0;
  logic       prev_txen = 1'b0;
  logic       last_valid = 1'b0;
  logic [7:0] last_byte  = 8'h00;

  always @(negedge CLK) begin
    if (Reset_n) begin
      if (tx_en) begin
        n_txen++;
        txen_cycs.push_back(cyc);
        check("txen_single", int'(prev_txen), 0);
        if (exp_q.size() == 0) begin
          check("txen_unexpected", 1, 0);
        end else begin
          check("tx_data", int'(tx_data), int'(exp_q[0]));
          if (ignore_left == 0) begin
            last_byte  = exp_q.pop_front();
            last_valid = 1'b1;
            n_frames++;
          end
        end
      end
      if (!tx_status && last_valid) check("tx_data_hold", int'(tx_data), int'(last_byte));
      prev_txen = tx_en;
    end else begin
      prev_txen = 1'b0;
    end
  end

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (!(!busy && tx_status) && k < max_cyc) begin
      @(negedge CLK);
      k++;
    end
    if (k >= max_cyc) check("idle_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_en"},    int'(tx_en),    0);
    check({pfx, "_tx_data"},  int'(tx_data),  0);
    check({pfx, "_full"},     int'(full),     0);
    check({pfx, "_empty"},    int'(empty),    1);
    check({pfx, "_count"},    int'(count),    0);
    check({pfx, "_overflow"}, int'(overflow), 0);
    check({pfx, "_busy"},     int'(busy),     0);
  endtask

  initial begin
    int push_cyc;
    int n0;
    int k;

    Reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    Reset_n = 1'b1;
    @(negedge CLK);

    // Single byte, latency and full frame
    frame_len = 120;
    txen_cycs.delete();
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    push_cyc = cyc + 1;
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle(300);
    check("lat_txen_count", txen_cycs.size(), 1);
    if (txen_cycs.size() > 0) check("lat_cycles", txen_cycs[0] - push_cyc, 2);
    check("single_empty", int'(empty), 1);
    check("single_busy",  int'(busy),  0);
    check("single_txdata", int'(tx_data), 8'hA5);

    // Burst to full while the serializer is busy, then one dropped push
    frame_len = 10;
    ser_hold  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      @(negedge CLK);
    end
    check("burst_full",  int'(full),  1);
    check("burst_count", int'(count), 16);
    check("burst_ovf0",  int'(overflow), 0);
    wr_data = 8'hFF;
    @(negedge CLK);
    wr_en = 1'b0;
    check("drop_ovf",   int'(overflow), 1);
    check("drop_count", int'(count), 16);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    check("clr_ovf", int'(overflow), 0);

    // Push into full FIFO on the same edge as the first pop, then drain
    n0 = n_frames;
    ser_hold = 1'b0;
    wr_en = 1'b1; wr_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge CLK);
    wr_en = 1'b0;
    check("pushpop_count", int'(count), 16);
    check("pushpop_ovf",   int'(overflow), 0);
    wait_idle(1000);
    check("drain_frames", n_frames - n0, 17);
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_empty", int'(empty), 1);

    // First start pulse ignored: one retry five cycles later
    txen_cycs.delete();
    ignore_left = 1;
    wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle(200);
    check("retry1_txens", txen_cycs.size(), 2);
    if (txen_cycs.size() >= 2) check("retry1_gap", txen_cycs[1] - txen_cycs[0], 5);
    check("retry1_ovf", int'(overflow), 0);

    // Every start pulse ignored: four pulses, byte dropped, overflow set
    txen_cycs.delete();
    ignore_left = 100;
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle(200);
    check("retryall_txens", txen_cycs.size(), 4);
    check("retryall_ovf",   int'(overflow), 1);
    check("retryall_busy",  int'(busy), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ignore_left = 0;
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;

    // Reset in WAIT_DONE with five bytes queued
    frame_len = 50;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
      @(negedge CLK);
    end
    wr_en = 1'b0;
    k = 0;
    while (tx_status && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 20) check("waitdone_timeout", 1, 0);
    check("pre_rst_count", int'(count), 5);
    #2 Reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    last_valid = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    n0 = n_txen;
    repeat (20) @(negedge CLK);
    check("post_rst_no_txen", n_txen - n0, 0);
    check("post_rst_empty", int'(empty), 1);
    check("post_rst_busy",  int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Buffered transmit front-end placed between the CPU bus write path and the UART serializer.
- Accepts bytes from bus writes into a FIFO and hands them one at a time to the serializer via its txen/txdata/txstatus handshake.
- Holds tx_data stable for the whole frame and lets the CPU burst-write without polling serializer status per byte.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
ADDR_W, 4, log2(DEPTH)

Ports:
CLK  in  1  system clock, all logic on posedge
Reset_n  in  1  reset, asynchronous, active-low
wr_en  in  1  push request, one byte per cycle
wr_data  in  8  byte to push
clr_ovf  in  1  clears sticky overflow flag
tx_status  in  1  serializer status; 1 = idle, 0 = busy
tx_en  out  1  one-cycle start pulse to serializer
tx_data  out  8  byte presented to serializer
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky; set when a push is dropped
busy  out  1  1 whenever FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (Reset_n low, async): FIFO pointers and count = 0; full=0, empty=1, tx_en=0, tx_data=8'h00, overflow=0, busy=0; FSM=IDLE. Reset mid-frame abandons the in-flight byte and all queued bytes.
- FIFO: wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH; count tracked separately, ADDR_W+1 bits.
- Push accepted when wr_en && (!full || pop this cycle). Push when full with no pop: data dropped, overflow<=1.
- Same-cycle push and pop: count unchanged, both pointers advance.
- overflow clears on clr_ovf; a same-cycle set takes priority over clr_ovf.
- Pop happens only in the IDLE->LAUNCH transition. The popped byte is registered into tx_data that same edge.
- FSM states:
  IDLE: if !empty && tx_status==1 -> pop, load tx_data, go LAUNCH.
  LAUNCH: tx_en=1 for exactly this cycle -> WAIT_BUSY.
  WAIT_BUSY: wait for tx_status==0 -> WAIT_DONE. If still 1 after 4 cycles, go back to LAUNCH and repulse (lost-start retry; bound 3 retries, then drop byte, set overflow, go IDLE).
  WAIT_DONE: wait for tx_status==1 -> IDLE.
- tx_en is registered: high only in the cycle after entering LAUNCH, never two consecutive cycles.
- tx_data changes only on a pop and is held through WAIT_DONE.
- Latency: empty FIFO with idle serializer, push at edge N -> tx_en high in cycle N+2.
- Back-to-back frames: a minimum of 1 IDLE cycle between tx_status rising and the next tx_en.
- full/empty/count are registered and reflect post-edge state.
- busy is combinational from state and empty.

Decomposition:
- Shared package (uart_pkg): FSM state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3), BUSY_TIMEOUT=4, MAX_RETRY=3, byte width 8.
- Sub-module sync_fifo (parameters DEPTH/ADDR_W/WIDTH; ports push, pop, din, dout, full, empty, count) holds storage and pointers.
- uart_tx_queue holds the FSM, the retry counter and the overflow flag.

Test Plan:
- Reset, then single push 8'hA5 with tx_status=1 -> tx_en pulse exactly 2 cycles later, tx_data=8'hA5; model tx_status low 120 cycles -> state returns IDLE, empty=1, busy=0.
- Burst-push 8'h01..8'h10 (16 bytes) in consecutive cycles while serializer busy -> full=1, count=16; a 17th push 8'hFF is dropped, overflow=1, queue content unchanged; clr_ovf -> overflow=0.
- Drain the 16 queued bytes with a serializer model -> tx_data sequence 01..10 in order, one tx_en per frame, tx_data stable across each frame.
- Push while full with a pop in the same cycle -> push accepted, count stays 16, overflow stays 0.
- Serializer model ignores the first tx_en (tx_status stays 1) -> second tx_en 5 cycles after the first; ignoring all pulses -> 4 tx_en total, byte dropped, overflow=1, FSM back to IDLE.
- Assert Reset_n low during WAIT_DONE with count=5 -> all outputs at reset values immediately; after release no tx_en until a new push.
